left_shift_sequencer: RTL and testbench

//  Multi-cycle left-shift controller for the datapath shifter.
//  - Accepts a WIDTH-bit operand and a shift amount.
//  - Shifts one bit per clock by chaining WIDTH/4 left_shifter_x1_4b slices.
//  - Reports the result, the last bit shifted out and a one-cycle done pulse.
//  - Sits between the datapath control FSM and the shifter slices, giving

---
 rtl/left_shift_sequencer_pkg.sv | 10 +
 rtl/left_shift_sequencer_shifter.sv | 17 +
 rtl/left_shift_sequencer.sv | 105 ++++++++++
 tb/tb_left_shift_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/left_shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle left-shift sequencer.
package left_shift_sequencer_pkg;
   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/left_shift_sequencer_shifter.sv
// 4-bit, one-position left shifter slice with carry in/out for chaining.
module left_shifter_x1_4b (
   input  logic       sh,
   input  logic       cin,
   input  logic [3:0] d,
   output logic [3:0] q,
   output logic       cout
);
   always_comb begin
      q    = d;
      cout = 1'b0;
      if (sh) begin
         q    = {d[2:0], cin};
         cout = d[3];
      end
   end
endmodule

// File: rtl/left_shift_sequencer.sv
// Sequencer: shifts the working register one bit per clock through a chain
// of 4-bit slices until the saturated shift amount is used up.
module left_shift_sequencer
   import left_shift_sequencer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic [CNT_W-1:0] amt,
   input  logic             fill,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             cout,
   output logic             err
);
   localparam int NS = WIDTH / SLICE_W;
   localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

   if (WIDTH % SLICE_W != 0 || WIDTH < SLICE_W) begin : g_chk_width
      $error("WIDTH must be a non-zero multiple of 4");
   end
   if ((1 << CNT_W) <= WIDTH) begin : g_chk_cnt
      $error("CNT_W too small to hold WIDTH");
   end

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             fill_q;
   logic [WIDTH-1:0] chain;
   logic [NS:0]      carry;
   logic             amt_big;
   logic [CNT_W-1:0] amt_sat;

   assign amt_big  = ({1'b0, amt} > {1'b0, WIDTH_CNT});
   assign amt_sat  = amt_big ? WIDTH_CNT : amt;
   assign carry[0] = fill_q;

   for (genvar i = 0; i < NS; i++) begin : g_slice
      left_shifter_x1_4b u_slice (
         .sh   (state == ST_SHIFT),
         .cin  (carry[i]),
         .d    (data_out[SLICE_W*i +: SLICE_W]),
         .q    (chain[SLICE_W*i +: SLICE_W]),
         .cout (carry[i+1])
      );
   end

   // busy/done are registered alongside the state so they track it exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         fill_q   <= 1'b0;
         data_out <= '0;
         cout     <= 1'b0;
         err      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  data_out <= data_in;
                  fill_q   <= fill;
                  cout     <= 1'b0;
                  err      <= amt_big;
                  cnt      <= amt_sat;
                  if (amt_sat == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_SHIFT;
                     busy  <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               data_out <= chain;
               cout     <= carry[NS];
               cnt      <= cnt - 1'b1;
               if (cnt == 1) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_left_shift_sequencer.sv
// Directed, table-driven bench for left_shift_sequencer (WIDTH=8, CNT_W=4).
module tb_left_shift_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] data_in;
   logic [3:0] amt;
   logic       fill;
   logic       busy, done, cout, err;
   logic [7:0] data_out;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] d;
      logic [3:0] a;
      logic       f;
      logic [7:0] exp_d;
      logic       exp_c;
      logic       exp_e;
      int         exp_busy;
   } vec_t;

   vec_t tbl[8];

   left_shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .amt(amt),
      .fill(fill), .busy(busy), .done(done), .data_out(data_out), .cout(cout),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Launch one operation and follow it to its done pulse.
   task automatic run_op(input vec_t v, input string name);
      int cyc, bcnt;
      @(negedge clk);
      data_in = v.d; amt = v.a; fill = v.f; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; bcnt = 0;
      while (!done && cyc < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         cyc++;
      end
      chk({name, " done_seen"}, 32'(done), 32'd1);
      chk({name, " latency"}, 32'(cyc), 32'(v.exp_busy));
      chk({name, " busy_cycles"}, 32'(bcnt), 32'(v.exp_busy));
      chk({name, " busy_in_done"}, 32'(busy), 32'd0);
      chk({name, " data_out"}, 32'(data_out), 32'(v.exp_d));
      chk({name, " cout"}, 32'(cout), 32'(v.exp_c));
      chk({name, " err"}, 32'(err), 32'(v.exp_e));
      @(negedge clk);
      chk({name, " done_width"}, 32'(done), 32'd0);
      chk({name, " hold_data"}, 32'(data_out), 32'(v.exp_d));
   endtask

   initial begin
      vec_t v;
      int   cyc;
      tbl[0] = '{8'hA6, 4'd1,  1'b0, 8'h4C, 1'b1, 1'b0, 1};
      tbl[1] = '{8'h5A, 4'd0,  1'b0, 8'h5A, 1'b0, 1'b0, 0};
      tbl[2] = '{8'hB1, 4'd3,  1'b1, 8'h8F, 1'b1, 1'b0, 3};
      tbl[3] = '{8'hFF, 4'd9,  1'b0, 8'h00, 1'b1, 1'b1, 8};
      tbl[4] = '{8'h3C, 4'd4,  1'b0, 8'hC0, 1'b1, 1'b0, 4};
      tbl[5] = '{8'h81, 4'd8,  1'b1, 8'hFF, 1'b1, 1'b0, 8};
      tbl[6] = '{8'h0F, 4'd15, 1'b1, 8'hFF, 1'b1, 1'b1, 8};
      tbl[7] = '{8'h5A, 4'd0,  1'b1, 8'h5A, 1'b0, 1'b0, 0};

      rst_n = 1'b0; start = 1'b0; data_in = '0; amt = '0; fill = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset data_out", 32'(data_out), 32'd0);
      chk("reset flags", {28'd0, busy, done, cout, err}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i));

      // start pulsed mid-shift must be ignored
      @(negedge clk);
      data_in = 8'h55; amt = 4'd4; fill = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      data_in = 8'hFF; amt = 4'd1; fill = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 40) begin @(negedge clk); cyc++; end
      chk("ignore_start done_seen", 32'(done), 32'd1);
      chk("ignore_start data_out", 32'(data_out), 32'h50);
      chk("ignore_start cout", 32'(cout), 32'd1);

      // asynchronous reset in the middle of a saturated shift
      @(negedge clk);
      data_in = 8'hC3; amt = 4'd12; fill = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_reset err", 32'(err), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset data_out", 32'(data_out), 32'd0);
      chk("midreset flags", {28'd0, busy, done, cout, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      repeat (10) begin @(negedge clk); if (done || busy) cyc++; end
      chk("abandoned no_done", 32'(cyc), 32'd0);
      run_op(tbl[2], "after_reset");

      // start held high: done every 4 cycles, nothing accepted in SHIFT/DONE
      @(negedge clk);
      data_in = 8'h81; amt = 4'd2; fill = 1'b0; start = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("held busy%0d", i), 32'(busy), 32'(i % 4 < 2));
         chk($sformatf("held done%0d", i), 32'(done), 32'(i % 4 == 2));
         if (i % 4 == 2) begin
            chk($sformatf("held data%0d", i), 32'(data_out), 32'h04);
            chk($sformatf("held cout%0d", i), 32'(cout), 32'd0);
         end
      end
      start = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
